sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_if.sv | 19 +
 rtl/sram_controller.sv | 113 +++++++++++
 tb/tb_sram_controller.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - memory-stage request/response bus for the SRAM controller
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - splits a 32-bit pipeline access into two 16-bit SRAM half accesses
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus,
  output logic [17:0]        sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int unsigned CW = $clog2(WAIT_CYCLES + 2);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          op_wr;
  logic [16:0]   word_q;
  logic [31:0]   data_q;
  logic [31:0]   rd_q;

  logic [31:0]   offset;
  logic          unused_offset_bits;
  logic          req;
  logic          active;
  logic          phase_end;

  // Unsigned wrap is intentional: addresses below BASE_ADDR land at the top of the word space.
  assign offset             = bus.address - 32'(BASE_ADDR);
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
  assign req                = bus.wr_en | bus.rd_en;
  assign active             = (state == LO) || (state == HI);
  assign phase_end          = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_wr  <= 1'b0;
      word_q <= '0;
      data_q <= '0;
      rd_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req) begin
            op_wr  <= bus.wr_en;
            word_q <= offset[18:2];
            data_q <= bus.write_data;
            state  <= LO;
          end
        end
        LO: begin
          if (phase_end) begin
            if (!op_wr) rd_q[15:0] <= sram_dq_in;
            state <= HI;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HI: begin
          if (phase_end) begin
            if (!op_wr) rd_q[31:16] <= sram_dq_in;
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // A request still held here belongs to the access just finished.
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    if (active) begin
      sram_addr  = {word_q, (state == HI)};
      sram_dq_oe = op_wr;
      sram_we_n  = !op_wr;
      sram_oe_n  = op_wr;
      if (op_wr) sram_dq_out = (state == HI) ? data_q[31:16] : data_q[15:0];
    end
  end

  assign bus.ready     = !(((state == IDLE) && req) || active);
  assign bus.read_data = rd_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed self-checking bench for sram_controller
module tb_sram_controller;
  localparam int WAITC = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_controller_if bus ();
  sram_controller_if bus0 ();

  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  logic [17:0] addr0;
  logic [15:0] dq_out0;
  logic [15:0] dq_in0;
  logic        dq_oe0, we_n0, oe_n0;

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .sram_addr(addr0), .sram_dq_out(dq_out0), .sram_dq_in(dq_in0),
    .sram_dq_oe(dq_oe0), .sram_we_n(we_n0), .sram_oe_n(oe_n0)
  );

  // SRAM model: a write only lands after the strobe is held WAITC+1 cycles on one address.
  logic [15:0] mem [0:262143];
  int          run = 0;
  logic [17:0] run_addr = '0;
  int          addr1_strobes = 0;

  always @(posedge clk) begin
    if (!sram_we_n) begin
      run      <= (run > 0 && run_addr == sram_addr) ? run + 1 : 1;
      run_addr <= sram_addr;
      if (run_addr == sram_addr && run == WAITC) mem[sram_addr] <= sram_dq_out;
      if (sram_addr == 18'd1) addr1_strobes <= addr1_strobes + 1;
    end else begin
      run <= 0;
    end
  end

  assign sram_dq_in = (sram_addr == 18'h3FFFE) ? 16'h0BAD :
                      (sram_addr == 18'h3FFFF) ? 16'hF00D :
                      (sram_addr == 18'd4)     ? 16'h3333 :
                      (sram_addr == 18'd5)     ? 16'h4444 : mem[sram_addr];
  assign dq_in0 = 16'h5A00 | {8'h00, addr0[7:0]};

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        cap_ready [0:15];
  logic [17:0] cap_addr  [0:15];
  logic [15:0] cap_dq    [0:15];
  logic        cap_we    [0:15];
  logic        cap_oe    [0:15];
  logic        cap_doe   [0:15];
  logic [31:0] cap_rd    [0:15];

  task automatic capture(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input int n, input bit hold);
    @(negedge clk);
    bus.wr_en = wr; bus.rd_en = rd; bus.address = a; bus.write_data = d;
    for (int i = 0; i < n; i++) begin
      #1;
      cap_ready[i] = bus.ready;   cap_addr[i] = sram_addr; cap_dq[i] = sram_dq_out;
      cap_we[i]    = sram_we_n;   cap_oe[i]   = sram_oe_n; cap_doe[i] = sram_dq_oe;
      cap_rd[i]    = bus.read_data;
      @(negedge clk);
      if (!hold) begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        bus.address = 32'hFFFF_FFF0; bus.write_data = 32'h0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.wr_en = 1'b1; bus.address = 32'd1028; bus.write_data = 32'h1;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if (sram_we_n !== 1'b1) $display("FAIL reset_priority we_n got %b want 1", sram_we_n);
    else pass_cnt++;
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({bus.ready, sram_we_n, sram_oe_n, sram_dq_oe} !== 4'b1110)
      $display("FAIL reset_ctrl got %b want 1110", {bus.ready, sram_we_n, sram_oe_n, sram_dq_oe});
    else pass_cnt++;
    total_cnt++;
    if ({sram_addr, sram_dq_out} !== 34'd0)
      $display("FAIL reset_bus addr %h dq %h want 0 0", sram_addr, sram_dq_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.read_data !== 32'd0) $display("FAIL reset_read_data got %h want 0", bus.read_data);
    else pass_cnt++;
  endtask

  task automatic test_write();
    int low;
    capture(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 6, 1'b0);
    low = 0;
    for (int i = 0; i < 6; i++) if (!cap_ready[i]) low++;
    total_cnt++;
    if (low !== 5 || cap_ready[5] !== 1'b1)
      $display("FAIL write_ready low cycles %0d done ready %b want 5 1", low, cap_ready[5]);
    else pass_cnt++;
    for (int i = 1; i < 5; i++) begin
      total_cnt++;
      if (cap_addr[i] !== ((i < 3) ? 18'd2 : 18'd3) ||
          cap_dq[i] !== ((i < 3) ? 16'hBEEF : 16'hDEAD) ||
          {cap_we[i], cap_oe[i], cap_doe[i]} !== 3'b011)
        $display("FAIL write_cycle%0d addr %h dq %h we/oe/doe %b%b%b", i,
                 cap_addr[i], cap_dq[i], cap_we[i], cap_oe[i], cap_doe[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({cap_we[5], cap_doe[5]} !== 2'b10 || cap_addr[5] !== 18'd0 || cap_dq[5] !== 16'd0)
      $display("FAIL write_done we %b doe %b addr %h dq %h want 1 0 0 0",
               cap_we[5], cap_doe[5], cap_addr[5], cap_dq[5]);
    else pass_cnt++;
    total_cnt++;
    if (mem[2] !== 16'hBEEF || mem[3] !== 16'hDEAD)
      $display("FAIL write_mem got %h %h want beef dead", mem[2], mem[3]);
    else pass_cnt++;
  endtask

  task automatic test_read();
    capture(1'b0, 1'b1, 32'd1028, 32'h0, 6, 1'b0);
    for (int i = 1; i < 5; i++) begin
      total_cnt++;
      if ({cap_we[i], cap_oe[i], cap_doe[i]} !== 3'b100 || cap_addr[i] !== ((i < 3) ? 18'd2 : 18'd3))
        $display("FAIL read_cycle%0d addr %h we/oe/doe %b%b%b", i,
                 cap_addr[i], cap_we[i], cap_oe[i], cap_doe[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cap_rd[5] !== 32'hDEADBEEF || cap_ready[5] !== 1'b1)
      $display("FAIL read_data got %h ready %b want deadbeef 1", cap_rd[5], cap_ready[5]);
    else pass_cnt++;
    capture(1'b1, 1'b0, 32'd1032, 32'h11112222, 6, 1'b0);
    total_cnt++;
    if (bus.read_data !== 32'hDEADBEEF)
      $display("FAIL read_hold_after_write got %h want deadbeef", bus.read_data);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    capture(1'b1, 1'b1, 32'd1024, 32'h12345678, 6, 1'b0);
    total_cnt++;
    if (cap_we[1] !== 1'b0 || cap_we[3] !== 1'b0 || cap_oe[1] !== 1'b1 ||
        cap_addr[1] !== 18'd0 || cap_addr[3] !== 18'd1)
      $display("FAIL simul_strobe we %b%b oe %b addr %h %h", cap_we[1], cap_we[3],
               cap_oe[1], cap_addr[1], cap_addr[3]);
    else pass_cnt++;
    total_cnt++;
    if (mem[0] !== 16'h5678 || mem[1] !== 16'h1234)
      $display("FAIL simul_mem got %h %h want 5678 1234", mem[0], mem[1]);
    else pass_cnt++;
    total_cnt++;
    if (bus.read_data !== 32'hDEADBEEF)
      $display("FAIL simul_read_data got %h want deadbeef", bus.read_data);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int strobes0;
    strobes0 = addr1_strobes;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.address = 32'd1024; bus.write_data = 32'hAAAA5555;
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if (sram_addr !== 18'd1 || sram_we_n !== 1'b0)
      $display("FAIL rstmid_first_hi addr %h we %b want 1 0", sram_addr, sram_we_n);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({sram_we_n, bus.ready, sram_oe_n, sram_dq_oe} !== 4'b1110 || bus.read_data !== 32'd0 ||
        sram_addr !== 18'd0)
      $display("FAIL rstmid_abort we/rdy/oe/doe %b%b%b%b rd %h addr %h", sram_we_n, bus.ready,
               sram_oe_n, sram_dq_oe, bus.read_data, sram_addr);
    else pass_cnt++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (mem[0] !== 16'h5555 || mem[1] !== 16'h1234 || addr1_strobes - strobes0 !== 1)
      $display("FAIL rstmid_mem got %h %h strobes %0d want 5555 1234 1", mem[0], mem[1],
               addr1_strobes - strobes0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int low, oe_cycles;
    low = 0; oe_cycles = 0;
    @(negedge clk);
    bus.rd_en = 1'b1; bus.address = 32'd1020;
    for (int i = 0; i < 12; i++) begin
      #1;
      cap_ready[i] = bus.ready; cap_addr[i] = sram_addr; cap_rd[i] = bus.read_data;
      if (!bus.ready) low++;
      if (!sram_oe_n) oe_cycles++;
      @(negedge clk);
      if (i == 5) bus.address = 32'd1032;
    end
    bus.rd_en = 1'b0;
    #1;
    total_cnt++;
    if (low !== 10 || cap_ready[5] !== 1'b1 || cap_ready[11] !== 1'b1 || cap_ready[6] !== 1'b0)
      $display("FAIL b2b_ready low %0d r5 %b r6 %b r11 %b want 10 1 0 1", low,
               cap_ready[5], cap_ready[6], cap_ready[11]);
    else pass_cnt++;
    total_cnt++;
    if (cap_addr[1] !== 18'h3FFFE || cap_addr[3] !== 18'h3FFFF ||
        cap_addr[7] !== 18'd4 || cap_addr[9] !== 18'd5)
      $display("FAIL b2b_addr got %h %h %h %h want 3fffe 3ffff 4 5",
               cap_addr[1], cap_addr[3], cap_addr[7], cap_addr[9]);
    else pass_cnt++;
    total_cnt++;
    if (cap_rd[5] !== 32'hF00D0BAD || cap_rd[11] !== 32'h44443333)
      $display("FAIL b2b_data got %h %h want f00d0bad 44443333", cap_rd[5], cap_rd[11]);
    else pass_cnt++;
    total_cnt++;
    if (oe_cycles !== 8 || bus.ready !== 1'b1 || sram_oe_n !== 1'b1)
      $display("FAIL b2b_count oe cycles %0d ready %b oe_n %b want 8 1 1",
               oe_cycles, bus.ready, sram_oe_n);
    else pass_cnt++;
  endtask

  task automatic test_wait0();
    logic        r [0:3];
    logic [17:0] a [0:3];
    @(negedge clk);
    bus0.rd_en = 1'b1; bus0.address = 32'd1040;
    for (int i = 0; i < 4; i++) begin
      #1;
      r[i] = bus0.ready; a[i] = addr0;
      @(negedge clk);
      bus0.rd_en = 1'b0; bus0.address = 32'h0;
    end
    total_cnt++;
    if ({r[0], r[1], r[2], r[3]} !== 4'b0001)
      $display("FAIL wait0_ready got %b want 0001", {r[0], r[1], r[2], r[3]});
    else pass_cnt++;
    total_cnt++;
    if (a[1] !== 18'd8 || a[2] !== 18'd9 || a[3] !== 18'd0)
      $display("FAIL wait0_addr got %h %h %h want 8 9 0", a[1], a[2], a[3]);
    else pass_cnt++;
    total_cnt++;
    if (bus0.read_data !== 32'h5A095A08)
      $display("FAIL wait0_data got %h want 5a095a08", bus0.read_data);
    else pass_cnt++;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = 32'h0; bus.write_data = 32'h0;
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.address = 32'h0; bus0.write_data = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    test_wait0();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
